// File: rtl/halflife_pkg.sv
// Shared types and default widths for the half-life decay sequencer.
package halflife_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 8;
    localparam int HW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_HALVE = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

endpackage

// File: rtl/halflife_sequencer.sv
// Sequences an external up/down/load counter through repeated half-life periods,
// halving the tracked amount at each expiry. Define HALFLIFE_ROUND_UP_EN for round-half-up halving.
module halflife_sequencer
    import halflife_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF,
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          tick_en,
    input  logic [AW-1:0] amount_in,
    input  logic [N-1:0]  period_in,
    input  logic [N-1:0]  cnt_value,
    output logic          cnt_load,
    output logic          cnt_up,
    output logic          cnt_down,
    output logic [N-1:0]  cnt_in,
    output logic [AW-1:0] amount_out,
    output logic [HW-1:0] halvings,
    output logic          halve_pulse,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [AW-1:0] amount_q, amount_d, amount_half;
    logic [HW-1:0] halvings_q, halvings_d;
    logic [N-1:0]  period_q, period_d;
    logic          halve_pulse_q, halve_pulse_d;
    logic          done_q, done_d;

`ifdef HALFLIFE_ROUND_UP_EN
    // One extra bit so that the all-ones amount does not wrap before the shift.
    logic [AW:0] amount_inc;
    assign amount_inc  = {1'b0, amount_q} + {{AW{1'b0}}, 1'b1};
    assign amount_half = amount_inc[AW:1];
`else
    assign amount_half = amount_q >> 1;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        amount_d      = amount_q;
        halvings_d    = halvings_q;
        period_d      = period_q;
        halve_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && period_in != '0) begin
                    amount_d   = amount_in;
                    halvings_d = '0;
                    if (amount_in <= AW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        period_d = period_in;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = abort ? S_ABORT : S_COUNT;
            S_COUNT: begin
                if (abort)                state_d = S_ABORT;
                else if (cnt_value == '0) state_d = S_HALVE;
            end
            S_HALVE: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    amount_d      = amount_half;
                    halvings_d    = (halvings_q == '1) ? halvings_q : halvings_q + HW'(1);
                    halve_pulse_d = 1'b1;
                    state_d       = (amount_half <= AW'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= S_IDLE;
            amount_q      <= '0;
            halvings_q    <= '0;
            period_q      <= '0;
            halve_pulse_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            amount_q      <= amount_d;
            halvings_q    <= halvings_d;
            period_q      <= period_d;
            halve_pulse_q <= halve_pulse_d;
            done_q        <= done_d;
        end
    end

    // Counter controls decode straight from state so the counter acts in the same cycle.
    assign cnt_load = (state_q == S_LOAD) || (state_q == S_ABORT);
    assign cnt_in   = (state_q == S_LOAD) ? period_q : '0;
    assign cnt_down = (state_q == S_COUNT) && (cnt_value != '0) && tick_en;
    assign cnt_up   = 1'b0;

    assign busy        = (state_q == S_LOAD) || (state_q == S_COUNT) ||
                         (state_q == S_HALVE) || (state_q == S_ABORT);
    assign amount_out  = amount_q;
    assign halvings    = halvings_q;
    assign halve_pulse = halve_pulse_q;
    assign done        = done_q;

endmodule

// File: tb/tb_halflife_sequencer.sv
// Closed-loop bench: sequencer driving a behavioural 4-bit load/up/down counter,
// checked against a decay model computed from the halving rules.
module tb_halflife_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, tick_en;
    logic [7:0] amount_in;
    logic [3:0] period_in, cnt_value, cnt_in, cnt_q;
    logic       cnt_load, cnt_up, cnt_down;
    logic [7:0] amount_out, halvings;
    logic       halve_pulse, busy, done;

    int total = 0;
    int bad   = 0;

    halflife_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick_en(tick_en),
        .amount_in(amount_in), .period_in(period_in), .cnt_value(cnt_value),
        .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_in(cnt_in),
        .amount_out(amount_out), .halvings(halvings), .halve_pulse(halve_pulse),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // The counter the sequencer is wired to in the real system.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (cnt_load) cnt_q <= cnt_in;
        else if (cnt_up)   cnt_q <= cnt_q + 4'd1;
        else if (cnt_down) cnt_q <= cnt_q - 4'd1;
    end
    assign cnt_value = cnt_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: tick_en always 1, mode 1: toggling, mode 2: random
    task automatic run(input int amt, input int per, input int mode);
        int exp_q[$];
        int a, k, cyc, pulses, last, viol, loads;
        bit finished;
        a = amt;
        while (a > 1) begin
`ifdef HALFLIFE_ROUND_UP_EN
            a = (a + 1) / 2;
`else
            a = a / 2;
`endif
            exp_q.push_back(a);
        end
        k = exp_q.size();
        amount_in = 8'(amt);
        period_in = 4'(per);
        tick_en   = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        if (per == 0) begin
            viol = 0;
            repeat (4) begin
                if (busy || done || cnt_load) viol++;
                step();
            end
            check("zero_period_ignored", viol, 0);
            return;
        end
        pulses = 0; last = 0; viol = 0; loads = 0; finished = 0; cyc = 0;
        while (!finished && cyc < 3000) begin
            if (cnt_up || (cnt_down && !tick_en)) viol++;
            if (cnt_load) loads++;
            if (halve_pulse) begin
                if (pulses < k) check("amount", amount_out, exp_q[pulses]);
                else viol++;
                pulses++;
                check("halvings", halvings, pulses);
                if (mode == 0 && pulses > 1) check("interval", cyc - last, per + 3);
                last = cyc;
            end
            if (done) begin
                finished = 1;
                check("pulse_count", pulses, k);
                check("final_amount", amount_out, (k > 0) ? exp_q[k-1] : amt);
                check("final_halvings", halvings, k);
                check("busy_at_done", busy, 0);
                if (mode == 0) check("done_cycle", cyc, k * (per + 3));
                if (k == 0) check("no_load", loads, 0);
                check("stray_ctrl", viol, 0);
                step();
                check("done_one_cycle", done, 0);
                check("amount_hold", amount_out, (k > 0) ? exp_q[k-1] : amt);
            end else begin
                case (mode)
                    0:       tick_en = 1'b1;
                    1:       tick_en = ~tick_en;
                    default: tick_en = 1'($urandom);
                endcase
                step();
                cyc++;
            end
        end
        if (!finished) check("timeout", 1, 0);
        tick_en = 1'b1;
    endtask

    task automatic wait_cnt2();
        int n;
        n = 0;
        while (!(busy && cnt_value == 4'd2 && !cnt_load) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("wait_cnt2_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; tick_en = 1'b0;
        amount_in = '0; period_in = '0;
        step();
        check("rst_amount", amount_out, 0);
        check("rst_halvings", halvings, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt_load", cnt_load, 0);
        rst = 1'b0;
        step();

        run(40, 3, 0);
        run(40, 3, 1);
        run(1, 5, 0);
        run(40, 0, 0);
        run(255, 15, 0);
        run(2, 1, 0);

        // Abort mid-count
        amount_in = 8'd40; period_in = 4'd3; tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_cnt2();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_load", cnt_load, 1);
        check("abort_cnt_in", cnt_in, 0);
        check("abort_busy", busy, 1);
        check("abort_no_done", done, 0);
        step();
        check("after_abort_busy", busy, 0);
        check("after_abort_done", done, 0);
        check("after_abort_amount", amount_out, 40);
        check("after_abort_halvings", halvings, 0);
        check("after_abort_cnt", cnt_value, 0);
        run(40, 3, 0);

        // Reset mid-count clears everything immediately
        amount_in = 8'd40; period_in = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_cnt2();
        rst = 1'b1;
        #1;
        check("midrst_amount", amount_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt_down", cnt_down, 0);
        check("midrst_cnt_load", cnt_load, 0);
        check("midrst_halve", halve_pulse, 0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
